// File: rtl/ct_ifu_sram_arb_pkg.sv
// Shared types and constants for the IFU SRAM arbiter/controller slice.
// Covers the FSM states and the default geometry of the 256x23 macro.
package ct_ifu_sram_arb_pkg;

    localparam int ARB_ADDR_WIDTH       = 8;
    localparam int ARB_DATA_WIDTH       = 23;
    localparam int DEFAULT_STARVE_LIMIT = 4;
    localparam int DEPTH                = 1 << ARB_ADDR_WIDTH;

    typedef enum logic {
        INIT,
        RUN
    } arb_state_e;

endpackage

// File: rtl/ct_ifu_sram_arb_ctrl_if.sv
// Requester handshakes, flush/busy status and the SRAM macro pins of the arbiter.
// The slave modport is the controller's view; the master modport is the surrounding logic.
interface ct_ifu_sram_arb_ctrl_if
    import ct_ifu_sram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = ARB_ADDR_WIDTH,
    parameter int DATA_WIDTH = ARB_DATA_WIDTH
);
    logic                  flush_i;
    logic                  init_busy_o;
    logic                  rd_req_i;
    logic [ADDR_WIDTH-1:0] rd_addr_i;
    logic                  rd_gnt_o;
    logic                  rd_rvalid_o;
    logic [DATA_WIDTH-1:0] rd_rdata_o;
    logic                  wr_req_i;
    logic [ADDR_WIDTH-1:0] wr_addr_i;
    logic [DATA_WIDTH-1:0] wr_data_i;
    logic [DATA_WIDTH-1:0] wr_be_i;
    logic                  wr_gnt_o;
    logic                  sram_cen_o;
    logic                  sram_gwen_o;
    logic [DATA_WIDTH-1:0] sram_wen_o;
    logic [ADDR_WIDTH-1:0] sram_a_o;
    logic [DATA_WIDTH-1:0] sram_d_o;
    logic [DATA_WIDTH-1:0] sram_q_i;

    modport slave (
        input  flush_i, rd_req_i, rd_addr_i, wr_req_i, wr_addr_i, wr_data_i, wr_be_i, sram_q_i,
        output init_busy_o, rd_gnt_o, rd_rvalid_o, rd_rdata_o, wr_gnt_o,
        output sram_cen_o, sram_gwen_o, sram_wen_o, sram_a_o, sram_d_o
    );

    modport master (
        output flush_i, rd_req_i, rd_addr_i, wr_req_i, wr_addr_i, wr_data_i, wr_be_i, sram_q_i,
        input  init_busy_o, rd_gnt_o, rd_rvalid_o, rd_rdata_o, wr_gnt_o,
        input  sram_cen_o, sram_gwen_o, sram_wen_o, sram_a_o, sram_d_o
    );

endinterface

// File: rtl/ct_ifu_sram_init_seq.sv
// Address sweep counter used to clear the whole SRAM array after reset or flush.
// The counter restarts from zero on flush, in either arbiter state.
module ct_ifu_sram_init_seq
    import ct_ifu_sram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = ARB_ADDR_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  active,
    input  logic                  restart,
    output logic [ADDR_WIDTH-1:0] init_cnt,
    output logic                  sweep_done
);

    always_ff @(posedge clk_i) begin
        if (rst_i || restart) begin
            init_cnt <= '0;
        end else if (active) begin
            init_cnt <= init_cnt + ADDR_WIDTH'(1);
        end
    end

    // A restart on the last entry wins, so the sweep goes round again.
    assign sweep_done = active && !restart && (&init_cnt);

endmodule

// File: rtl/ct_ifu_sram_arb_ctrl.sv
// Clears the IFU SRAM after reset/flush, then arbitrates its single port between
// lookup reads and refill writes (write-first, reads protected from starvation).
module ct_ifu_sram_arb_ctrl
    import ct_ifu_sram_arb_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = ARB_ADDR_WIDTH,
    parameter int                    DATA_WIDTH   = ARB_DATA_WIDTH,
    parameter int                    STARVE_LIMIT = DEFAULT_STARVE_LIMIT,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    ct_ifu_sram_arb_ctrl_if.slave  bus
);

    localparam int                    STARVE_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0]   STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    arb_state_e            state;
    logic [STARVE_W-1:0]   starve_cnt;
    logic [ADDR_WIDTH-1:0] init_cnt;
    logic [ADDR_WIDTH-1:0] a_hold;
    logic [DATA_WIDTH-1:0] d_hold;
    logic                  rd_rvalid;
    logic                  sweep_done;
    logic                  in_init;
    logic                  in_run;
    logic                  starved;
    logic                  rd_gnt;
    logic                  wr_gnt;
    logic                  cen;
    logic                  gwen;
    logic [DATA_WIDTH-1:0] wen;
    logic [ADDR_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] d;

    ct_ifu_sram_init_seq #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_init_seq (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .active     (in_init),
        .restart    (bus.flush_i),
        .init_cnt   (init_cnt),
        .sweep_done (sweep_done)
    );

    assign in_init = !rst_i && (state == INIT);
    assign in_run  = !rst_i && (state == RUN) && !bus.flush_i;

    // A starved read only overrides the write while the read is still requested.
    assign starved = (starve_cnt == STARVE_MAX) && bus.rd_req_i;
    assign wr_gnt  = in_run && bus.wr_req_i && !starved;
    assign rd_gnt  = in_run && bus.rd_req_i && !wr_gnt;

    always_comb begin
        cen  = 1'b1;
        gwen = 1'b1;
        wen  = '1;
        a    = a_hold;
        d    = d_hold;
        if (in_init) begin
            cen  = 1'b0;
            gwen = 1'b0;
            wen  = '0;
            a    = init_cnt;
            d    = INIT_VALUE;
        end else if (wr_gnt) begin
            cen  = 1'b0;
            gwen = 1'b0;
            wen  = ~bus.wr_be_i;
            a    = bus.wr_addr_i;
            d    = bus.wr_data_i;
        end else if (rd_gnt) begin
            cen  = 1'b0;
            a    = bus.rd_addr_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= INIT;
            starve_cnt <= '0;
            rd_rvalid  <= 1'b0;
            a_hold     <= '0;
            d_hold     <= '0;
        end else begin
            rd_rvalid <= rd_gnt;
            a_hold    <= a;
            d_hold    <= d;
            case (state)
                INIT:    if (sweep_done) state <= RUN;
                RUN:     if (bus.flush_i) state <= INIT;
                default: state <= INIT;
            endcase
            if ((state != RUN) || bus.flush_i || !bus.rd_req_i || rd_gnt) begin
                starve_cnt <= '0;
            end else if (starve_cnt != STARVE_MAX) begin
                starve_cnt <= starve_cnt + STARVE_W'(1);
            end
        end
    end

    assign bus.init_busy_o = rst_i || (state == INIT);
    assign bus.rd_gnt_o    = rd_gnt;
    assign bus.wr_gnt_o    = wr_gnt;
    assign bus.rd_rvalid_o = rd_rvalid;
    assign bus.rd_rdata_o  = bus.sram_q_i;
    assign bus.sram_cen_o  = cen;
    assign bus.sram_gwen_o = gwen;
    assign bus.sram_wen_o  = wen;
    assign bus.sram_a_o    = a;
    assign bus.sram_d_o    = d;

endmodule

// File: tb/tb_ct_ifu_sram_arb_ctrl.sv
// Scoreboard bench for ct_ifu_sram_arb_ctrl: expected macro accesses and read data are
// queued by the stimulus and popped by a monitor whenever the pins show an access or rvalid.
module tb_ct_ifu_sram_arb_ctrl;
    import ct_ifu_sram_arb_pkg::*;

    localparam int AW = 8;
    localparam int DW = 23;

    typedef struct {
        logic          gwen;
        logic [AW-1:0] a;
        logic [DW-1:0] wen;
        logic [DW-1:0] d;
        bit            check_d;
    } acc_t;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    acc_t          acc_q[$];
    logic [DW-1:0] rdata_q[$];
    acc_t          mon_exp;
    logic [DW-1:0] mon_rdata;
    int            compared   = 0;
    int            mismatched = 0;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] q;

    always #5 clk_i = ~clk_i;

    ct_ifu_sram_arb_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

    ct_ifu_sram_arb_ctrl #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .STARVE_LIMIT (4),
        .INIT_VALUE   (23'h0)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    // Behavioural macro: active-low controls, per-bit write mask, 1-cycle read latency.
    always @(posedge clk_i) begin
        if (bus.sram_cen_o == 1'b0) begin
            if (bus.sram_gwen_o == 1'b0)
                mem[bus.sram_a_o] <= (mem[bus.sram_a_o] & bus.sram_wen_o) | (bus.sram_d_o & ~bus.sram_wen_o);
            else
                q <= mem[bus.sram_a_o];
        end
    end
    assign bus.sram_q_i = q;

    always @(negedge clk_i) begin
        if (bus.sram_cen_o !== 1'b1) begin
            compared++;
            if (acc_q.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL unexpected_access: got cen=%b gwen=%b a=%0h, required no access",
                         bus.sram_cen_o, bus.sram_gwen_o, bus.sram_a_o);
            end else begin
                mon_exp = acc_q.pop_front();
                if (bus.sram_gwen_o !== mon_exp.gwen || bus.sram_a_o !== mon_exp.a ||
                    bus.sram_wen_o !== mon_exp.wen || (mon_exp.check_d && bus.sram_d_o !== mon_exp.d)) begin
                    mismatched++;
                    $display("[TB] FAIL sram_access: got gwen=%b a=%0h wen=%0h d=%0h, required gwen=%b a=%0h wen=%0h d=%0h",
                             bus.sram_gwen_o, bus.sram_a_o, bus.sram_wen_o, bus.sram_d_o,
                             mon_exp.gwen, mon_exp.a, mon_exp.wen, mon_exp.d);
                end
            end
        end
        if (bus.rd_rvalid_o !== 1'b0) begin
            compared++;
            if (rdata_q.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL unexpected_rvalid: got rvalid=%b rdata=%0h, required rvalid=0",
                         bus.rd_rvalid_o, bus.rd_rdata_o);
            end else begin
                mon_rdata = rdata_q.pop_front();
                if (bus.rd_rdata_o !== mon_rdata) begin
                    mismatched++;
                    $display("[TB] FAIL rd_rdata: got %0h, required %0h", bus.rd_rdata_o, mon_rdata);
                end
            end
        end
    end

    function automatic void pushInit(int n);
        for (int i = 0; i < n; i++)
            acc_q.push_back('{gwen: 1'b0, a: AW'(i), wen: '0, d: '0, check_d: 1'b1});
    endfunction

    function automatic void pushWrite(logic [AW-1:0] a, logic [DW-1:0] d, logic [DW-1:0] be);
        acc_q.push_back('{gwen: 1'b0, a: a, wen: ~be, d: d, check_d: 1'b1});
    endfunction

    function automatic void pushRead(logic [AW-1:0] a, logic [DW-1:0] exp_data);
        acc_q.push_back('{gwen: 1'b1, a: a, wen: '1, d: '0, check_d: 1'b0});
        rdata_q.push_back(exp_data);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge and return at the falling edge.
    task automatic applyStimulus(input logic rst, input logic flush,
                                 input logic rd_req, input logic [AW-1:0] rd_addr,
                                 input logic wr_req, input logic [AW-1:0] wr_addr,
                                 input logic [DW-1:0] wr_data, input logic [DW-1:0] wr_be);
        @(posedge clk_i);
        #1;
        rst_i         = rst;
        bus.flush_i   = flush;
        bus.rd_req_i  = rd_req;
        bus.rd_addr_i = rd_addr;
        bus.wr_req_i  = wr_req;
        bus.wr_addr_i = wr_addr;
        bus.wr_data_i = wr_data;
        bus.wr_be_i   = wr_be;
        @(negedge clk_i);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, '0, '0);
    endtask

    // Called right after sweep cycle 1 has been applied.
    task automatic finishSweep(input string tag);
        idle(255);
        checkOutput({tag, "_busy_c256"}, 32'(bus.init_busy_o), 32'd1);
        idle(1);
        checkOutput({tag, "_busy_c257"}, 32'(bus.init_busy_o), 32'd0);
    endtask

    initial begin
        bus.flush_i   = 1'b0;
        bus.rd_req_i  = 1'b1;
        bus.rd_addr_i = '0;
        bus.wr_req_i  = 1'b1;
        bus.wr_addr_i = '0;
        bus.wr_data_i = '0;
        bus.wr_be_i   = '1;

        @(negedge clk_i);
        checkOutput("rst_cen",    32'(bus.sram_cen_o),  32'd1);
        checkOutput("rst_gwen",   32'(bus.sram_gwen_o), 32'd1);
        checkOutput("rst_wen",    32'(bus.sram_wen_o),  32'h7FFFFF);
        checkOutput("rst_rd_gnt", 32'(bus.rd_gnt_o),    32'd0);
        checkOutput("rst_wr_gnt", 32'(bus.wr_gnt_o),    32'd0);
        checkOutput("rst_busy",   32'(bus.init_busy_o), 32'd1);
        @(posedge clk_i);

        pushInit(256);
        pushWrite(8'h3C, 23'h5A5A5, '1);
        for (int i = 1; i <= 256; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1, 8'h3C, 23'h5A5A5, '1);
            checkOutput("init_no_wr_gnt", 32'(bus.wr_gnt_o),    32'd0);
            checkOutput("init_busy",      32'(bus.init_busy_o), 32'd1);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1, 8'h3C, 23'h5A5A5, '1);
        checkOutput("run_busy",     32'(bus.init_busy_o), 32'd0);
        checkOutput("first_wr_gnt", 32'(bus.wr_gnt_o),    32'd1);

        pushRead(8'h3C, 23'h5A5A5);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, '0, '0, '0);
        checkOutput("rd_gnt_3c",       32'(bus.rd_gnt_o),    32'd1);
        checkOutput("rvalid_with_gnt", 32'(bus.rd_rvalid_o), 32'd0);

        pushWrite(8'h3C, 23'h0, 23'h0000FF);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1, 8'h3C, 23'h0, 23'h0000FF);
        checkOutput("partial_wr_gnt",   32'(bus.wr_gnt_o),    32'd1);
        checkOutput("rvalid_after_gnt", 32'(bus.rd_rvalid_o), 32'd1);

        pushRead(8'h3C, 23'h5A500);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, '0, '0, '0);
        checkOutput("rd_gnt_partial", 32'(bus.rd_gnt_o), 32'd1);

        for (int c = 1; c <= 4; c++) pushWrite(8'h10, 23'h111111, '1);
        pushRead(8'h3C, 23'h5A500);
        pushWrite(8'h10, 23'h111111, '1);
        for (int c = 1; c <= 6; c++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 8'h3C, 1'b1, 8'h10, 23'h111111, '1);
            checkOutput($sformatf("starve_wr_gnt_c%0d", c), 32'(bus.wr_gnt_o), (c == 5) ? 32'd0 : 32'd1);
            checkOutput($sformatf("starve_rd_gnt_c%0d", c), 32'(bus.rd_gnt_o), (c == 5) ? 32'd1 : 32'd0);
        end

        pushRead(8'h10, 23'h111111);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h10, 1'b0, '0, '0, '0);
        checkOutput("rd_gnt_10", 32'(bus.rd_gnt_o), 32'd1);

        pushInit(256);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h3C, 1'b1, 8'h10, 23'h111111, '1);
        checkOutput("flush_rd_gnt", 32'(bus.rd_gnt_o),   32'd0);
        checkOutput("flush_wr_gnt", 32'(bus.wr_gnt_o),   32'd0);
        checkOutput("flush_cen",    32'(bus.sram_cen_o), 32'd1);
        idle(1);
        finishSweep("flush_sweep");

        pushRead(8'h3C, 23'h0);
        pushRead(8'h10, 23'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, '0, '0, '0);
        checkOutput("post_flush_rd_3c", 32'(bus.rd_gnt_o), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h10, 1'b0, '0, '0, '0);
        checkOutput("post_flush_rd_10", 32'(bus.rd_gnt_o), 32'd1);

        pushInit(100);
        pushInit(256);
        applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0, '0, '0, '0);
        idle(100);
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, '0, '0);
        checkOutput("midrst_cen",  32'(bus.sram_cen_o),  32'd1);
        checkOutput("midrst_busy", 32'(bus.init_busy_o), 32'd1);
        idle(1);
        finishSweep("rst_sweep");

        pushInit(51);
        pushInit(256);
        applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0, '0, '0, '0);
        idle(50);
        applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0, '0, '0, '0);
        checkOutput("midflush_busy", 32'(bus.init_busy_o), 32'd1);
        idle(1);
        finishSweep("midflush_sweep");

        pushWrite(8'h05, 23'h00ABCD, '1);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1, 8'h05, 23'h00ABCD, '1);
        checkOutput("wr_gnt_05", 32'(bus.wr_gnt_o), 32'd1);
        for (int i = 0; i < 16; i++) pushRead(AW'(i), (i == 5) ? 23'h00ABCD : 23'h0);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, AW'(i), 1'b0, '0, '0, '0);
            checkOutput($sformatf("stream_rd_gnt_%0d", i), 32'(bus.rd_gnt_o), 32'd1);
            if (i > 0)
                checkOutput($sformatf("stream_rvalid_%0d", i), 32'(bus.rd_rvalid_o), 32'd1);
        end
        idle(1);
        checkOutput("stream_rvalid_tail", 32'(bus.rd_rvalid_o), 32'd1);
        idle(1);
        checkOutput("stream_rvalid_end",  32'(bus.rd_rvalid_o), 32'd0);

        idle(2);
        checkOutput("acc_q_drained",   32'(acc_q.size()),   32'd0);
        checkOutput("rdata_q_drained", 32'(rdata_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
